// File: rtl/product_accumulator.sv
// product_accumulator: sums a valid/ready stream of unsigned PW-bit products
// in blocks of COUNT and presents each block sum on a held valid/ready output.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : product input handshake; prod is the product
//   out_valid/out_ready : block-sum output handshake; sum is the result
//   cnt                 : products accepted in the current block
//   ovf                 : block saturated (ACC_SAT_EN only, else tied 0)
// Optional macro ACC_SAT_EN: saturating accumulation with overflow flag.
module product_accumulator #(
  parameter int PW    = 16,
  parameter int AW    = 24,
  parameter int COUNT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] prod,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] sum,
  output logic [7:0]    cnt,
  output logic          ovf
);

  typedef enum logic [1:0] {
    ACCUM = 2'b00,
    HOLD  = 2'b01
  } state_e;

  localparam logic [7:0] LAST = 8'(COUNT - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [AW-1:0] sum_q, sum_d;
  logic          out_valid_q, out_valid_d;
  logic [AW-1:0] add_res;
  logic          carry;

`ifdef ACC_SAT_EN
  logic [AW:0]   add_w;
  logic          ovf_q, ovf_d;
  logic          blk_ovf_q, blk_ovf_d;

  // Once acc clamps to all-ones, any further non-zero add carries again,
  // so the clamp persists for the remainder of the block.
  always_comb begin
    add_w   = {1'b0, acc_q} + {{(AW + 1 - PW){1'b0}}, prod};
    carry   = add_w[AW];
    add_res = carry ? '1 : add_w[AW-1:0];
  end
`else
  always_comb begin
    carry   = 1'b0;
    add_res = acc_q + {{(AW - PW){1'b0}}, prod};
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
`ifdef ACC_SAT_EN
      ovf_q       <= 1'b0;
      blk_ovf_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
`ifdef ACC_SAT_EN
      ovf_q       <= ovf_d;
      blk_ovf_q   <= blk_ovf_d;
`endif
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    out_valid_d = out_valid_q;
`ifdef ACC_SAT_EN
    ovf_d       = ovf_q;
    blk_ovf_d   = blk_ovf_q;
`endif
    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          if (cnt_q == LAST) begin
            sum_d       = add_res;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = HOLD;
`ifdef ACC_SAT_EN
            ovf_d       = blk_ovf_q | carry;
            blk_ovf_d   = 1'b0;
`endif
          end else begin
            acc_d = add_res;
            cnt_d = cnt_q + 8'd1;
`ifdef ACC_SAT_EN
            blk_ovf_d = blk_ovf_q | carry;
`endif
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
`ifdef ACC_SAT_EN
          ovf_d       = 1'b0;
`endif
        end
      end
      default: begin
        state_d = ACCUM;
        acc_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = out_valid_q;
    sum       = sum_q;
    cnt       = cnt_q;
`ifdef ACC_SAT_EN
    ovf       = ovf_q;
`else
    ovf       = 1'b0;
`endif
  end

endmodule
